// File: rtl/dilution_tree_sequencer.sv
// Timed dispense/mix/read controller for the 4-layer protein dilution fabric.
// Optional ASSAY_PAUSE_EN adds a pause input that freezes the assay timeline.
module dilution_tree_sequencer #(
  parameter int unsigned DISPENSE_CYCLES = 64,
  parameter int unsigned MIX_CYCLES      = 1024,
  parameter int unsigned READ_CYCLES     = 16,
  parameter int unsigned TIMER_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
`ifdef ASSAY_PAUSE_EN
  input  logic        pause,
`endif
  output logic        ds_sample,
  output logic [6:0]  ds_buffer,
  output logic [7:0]  ds_reagent,
  output logic [3:0]  mix_active,
  output logic [2:0]  detect_sel,
  output logic        detect_strobe,
  input  logic [11:0] detect_data,
  output logic        result_valid,
  output logic [2:0]  result_idx,
  output logic [11:0] result_data,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [2:0] {StIdle, StDisp, StMix, StRead, StDone} state_e;

  localparam logic [TIMER_W-1:0] DispLoad = TIMER_W'(DISPENSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MixLoad  = TIMER_W'(MIX_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ReadLoad = TIMER_W'(READ_CYCLES - 1);

  logic pause_in;
`ifdef ASSAY_PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         layer_q, layer_d;
  logic [2:0]         chan_q, chan_d;
  // Set when the current cycle is frozen; a frozen cycle does not consume timeline.
  logic               paused_q, paused_d;
  logic               hold;

  logic        ds_sample_d, detect_strobe_d, result_valid_d, busy_d, done_d, aborted_d;
  logic [6:0]  ds_buffer_d;
  logic [7:0]  ds_reagent_d;
  logic [3:0]  mix_active_d;
  logic [2:0]  detect_sel_d, result_idx_d;
  logic [11:0] result_data_d;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    layer_d        = layer_q;
    chan_d         = chan_q;
    result_data_d  = result_data;
    result_idx_d   = result_idx;
    result_valid_d = 1'b0;
    aborted_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StDisp;
          timer_d = DispLoad;
          layer_d = 2'd0;
          chan_d  = 3'd0;
        end
      end
      StDone: begin
        state_d   = StIdle;
        timer_d   = '0;
        layer_d   = 2'd0;
        chan_d    = 3'd0;
        aborted_d = abort;
      end
      default: begin
        if (abort) begin
          state_d   = StIdle;
          timer_d   = '0;
          layer_d   = 2'd0;
          chan_d    = 3'd0;
          aborted_d = 1'b1;
        end else if (!paused_q) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TIMER_W'(1);
          end else begin
            case (state_q)
              StDisp: begin
                state_d = StMix;
                timer_d = MixLoad;
              end
              StMix: begin
                if (layer_q != 2'd3) begin
                  layer_d = layer_q + 2'd1;
                  state_d = StDisp;
                  timer_d = DispLoad;
                end else begin
                  state_d = StRead;
                  chan_d  = 3'd0;
                  timer_d = ReadLoad;
                end
              end
              default: begin
                result_data_d  = detect_data;
                result_idx_d   = chan_q;
                result_valid_d = 1'b1;
                if (chan_q != 3'd7) begin
                  chan_d  = chan_q + 3'd1;
                  timer_d = ReadLoad;
                end else begin
                  state_d = StDone;
                  timer_d = '0;
                end
              end
            endcase
          end
        end
      end
    endcase

    // Pause only bites while the assay stays inside its timed phases.
    hold = pause_in && (state_q inside {StDisp, StMix, StRead})
                    && (state_d inside {StDisp, StMix, StRead});

    ds_sample_d  = 1'b0;
    ds_buffer_d  = 7'd0;
    ds_reagent_d = 8'd0;
    if (state_d == StDisp && !hold) begin
      case (layer_d)
        2'd0: begin
          ds_sample_d = 1'b1;
          ds_buffer_d = 7'b0000001;
        end
        2'd1:    ds_buffer_d  = 7'b0000110;
        2'd2:    ds_buffer_d  = 7'b1111000;
        default: ds_reagent_d = 8'hff;
      endcase
    end
    mix_active_d    = (state_d == StMix) ? (4'b0001 << layer_d) : 4'd0;
    detect_sel_d    = (state_d == StRead) ? chan_d : 3'd0;
    detect_strobe_d = (state_d == StRead) && (timer_d == ReadLoad) && !hold;
    busy_d          = (state_d != StIdle);
    done_d          = (state_d == StDone);
    paused_d        = hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      layer_q       <= 2'd0;
      chan_q        <= 3'd0;
      paused_q      <= 1'b0;
      ds_sample     <= 1'b0;
      ds_buffer     <= 7'd0;
      ds_reagent    <= 8'd0;
      mix_active    <= 4'd0;
      detect_sel    <= 3'd0;
      detect_strobe <= 1'b0;
      result_valid  <= 1'b0;
      result_idx    <= 3'd0;
      result_data   <= 12'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      layer_q       <= layer_d;
      chan_q        <= chan_d;
      paused_q      <= paused_d;
      ds_sample     <= ds_sample_d;
      ds_buffer     <= ds_buffer_d;
      ds_reagent    <= ds_reagent_d;
      mix_active    <= mix_active_d;
      detect_sel    <= detect_sel_d;
      detect_strobe <= detect_strobe_d;
      result_valid  <= result_valid_d;
      result_idx    <= result_idx_d;
      result_data   <= result_data_d;
      busy          <= busy_d;
      done          <= done_d;
      aborted       <= aborted_d;
    end
  end

endmodule

// File: tb/tb_dilution_tree_sequencer.sv
// Directed bench: full runs, abort, ignored start, reset, all-ones boundary and optional pause.
module tb_dilution_tree_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, abort, start1;
  logic        ds_sample, detect_strobe, result_valid, busy, done, aborted;
  logic [6:0]  ds_buffer;
  logic [7:0]  ds_reagent;
  logic [3:0]  mix_active;
  logic [2:0]  detect_sel, result_idx;
  logic [11:0] detect_data, result_data;

  logic        b_sample, b_strobe, b_rv, b_busy, b_done, b_aborted;
  logic [6:0]  b_buffer;
  logic [7:0]  b_reagent;
  logic [3:0]  b_mix;
  logic [2:0]  b_sel, b_idx;
  logic [11:0] b_ddata, b_rdata;

`ifdef ASSAY_PAUSE_EN
  logic pause;
  logic pause1;
`endif

  assign detect_data = 12'h100 + {9'd0, detect_sel};
  assign b_ddata     = 12'h100 + {9'd0, b_sel};

  dilution_tree_sequencer #(
    .DISPENSE_CYCLES(2), .MIX_CYCLES(3), .READ_CYCLES(2), .TIMER_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef ASSAY_PAUSE_EN
    .pause(pause),
`endif
    .ds_sample(ds_sample), .ds_buffer(ds_buffer), .ds_reagent(ds_reagent),
    .mix_active(mix_active), .detect_sel(detect_sel), .detect_strobe(detect_strobe),
    .detect_data(detect_data), .result_valid(result_valid), .result_idx(result_idx),
    .result_data(result_data), .busy(busy), .done(done), .aborted(aborted)
  );

  dilution_tree_sequencer #(
    .DISPENSE_CYCLES(1), .MIX_CYCLES(1), .READ_CYCLES(1), .TIMER_W(4)
  ) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
`ifdef ASSAY_PAUSE_EN
    .pause(pause1),
`endif
    .ds_sample(b_sample), .ds_buffer(b_buffer), .ds_reagent(b_reagent),
    .mix_active(b_mix), .detect_sel(b_sel), .detect_strobe(b_strobe),
    .detect_data(b_ddata), .result_valid(b_rv), .result_idx(b_idx),
    .result_data(b_rdata), .busy(b_busy), .done(b_done), .aborted(b_aborted)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at cycle 0 of a run (first busy cycle); schedule for D=2, M=3, R=2.
  task automatic full_run(input string tag, input bit poke);
    int done_at = -1;
    int busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      logic       e_sample, e_strobe, e_rv;
      logic [6:0] e_buf;
      logic [7:0] e_reag;
      logic [3:0] e_mix;
      logic [2:0] e_sel, e_idx;
      e_sample = (n < 2);
      e_buf    = (n < 2) ? 7'h01 : (n >= 5 && n < 7) ? 7'h06 : (n >= 10 && n < 12) ? 7'h78 : 7'h00;
      e_reag   = (n >= 15 && n < 17) ? 8'hff : 8'h00;
      e_mix    = (n >= 2 && n < 5) ? 4'h1 : (n >= 7 && n < 10) ? 4'h2 :
                 (n >= 12 && n < 15) ? 4'h4 : (n >= 17 && n < 20) ? 4'h8 : 4'h0;
      e_sel    = (n >= 20 && n < 36) ? 3'((n - 20) / 2) : 3'd0;
      e_strobe = (n >= 20 && n < 36) && (n % 2 == 0);
      e_rv     = (n >= 22 && n <= 36) && (n % 2 == 0);
      e_idx    = 3'((n - 22) / 2);
      check($sformatf("%s n=%0d valves", tag, n), {ds_sample, ds_buffer, ds_reagent},
            {e_sample, e_buf, e_reag});
      check($sformatf("%s n=%0d mix", tag, n), mix_active, e_mix);
      check($sformatf("%s n=%0d detect", tag, n), {detect_sel, detect_strobe}, {e_sel, e_strobe});
      check($sformatf("%s n=%0d status", tag, n), {busy, done, aborted, result_valid},
            {n <= 36, n == 36, 1'b0, e_rv});
      if (e_rv)
        check($sformatf("%s n=%0d result", tag, n), {result_idx, result_data},
              {e_idx, 12'h100 + {9'd0, e_idx}});
      if (done) done_at = n;
      if (busy) busy_cnt++;
      start = poke && ((n < 36 && n % 7 == 3) || n == 36);
      tick();
    end
    start = 1'b0;
    check({tag, " done_at"}, done_at, 36);
    check({tag, " busy_cycles"}, busy_cnt, 37);
  endtask

  initial begin
    int cnt;
    start = 1'b0; abort = 1'b0; start1 = 1'b0;
`ifdef ASSAY_PAUSE_EN
    pause = 1'b0; pause1 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ds_sample, ds_buffer, ds_reagent, mix_active, detect_sel, detect_strobe,
          result_valid, result_idx, result_data, busy, done, aborted}, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {busy, done, aborted}, 3'b000);

    // Plain full run
    start = 1'b1;
    tick();
    start = 1'b0;
    full_run("run1", 1'b0);

    // Abort during layer-2 mix
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("abort_pre_mix", mix_active, 4'h4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ack", {busy, aborted, done, result_valid, mix_active, ds_sample, ds_buffer,
          ds_reagent, detect_sel, detect_strobe}, {4'b0100, 4'h0, 1'b0, 7'h0, 8'h0, 3'h0, 1'b0});
    tick();
    check("abort_one_cycle", aborted, 1'b0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy || done || result_valid || aborted) cnt++;
      tick();
    end
    check("abort_quiet_after", cnt, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    full_run("rerun", 1'b0);

    // Start pulses while busy must not disturb timing
    start = 1'b1;
    tick();
    start = 1'b0;
    full_run("poke", 1'b1);

    // start and abort together in idle: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", {busy, aborted}, 2'b00);
    tick();
    check("start_abort_idle_later", busy, 1'b0);

    // Asynchronous reset mid-run while layer-1 valves are open
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_reset_valves", ds_buffer, 7'h06);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {ds_sample, ds_buffer, ds_reagent, mix_active, detect_sel,
          detect_strobe, result_valid, result_idx, result_data, busy, done, aborted}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("busy_after_reset", busy, 1'b0);

    // Boundary: every phase one cycle long
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cnt = -1;
    for (int n = 0; n < 20; n++) begin
      logic [6:0] e_buf;
      logic [3:0] e_mix;
      logic [2:0] e_sel, e_idx;
      logic       e_rd, e_rv;
      e_buf = (n == 0) ? 7'h01 : (n == 2) ? 7'h06 : (n == 4) ? 7'h78 : 7'h00;
      e_mix = (n == 1) ? 4'h1 : (n == 3) ? 4'h2 : (n == 5) ? 4'h4 : (n == 7) ? 4'h8 : 4'h0;
      e_rd  = (n >= 8 && n < 16);
      e_rv  = (n >= 9 && n <= 16);
      e_sel = e_rd ? 3'(n - 8) : 3'd0;
      e_idx = 3'(n - 9);
      check($sformatf("one n=%0d valves", n), {b_sample, b_buffer, b_reagent},
            {n == 0, e_buf, (n == 6) ? 8'hff : 8'h00});
      check($sformatf("one n=%0d mix", n), b_mix, e_mix);
      check($sformatf("one n=%0d detect", n), {b_sel, b_strobe}, {e_sel, e_rd});
      check($sformatf("one n=%0d status", n), {b_busy, b_done, b_aborted, b_rv},
            {n <= 16, n == 16, 1'b0, e_rv});
      if (e_rv)
        check($sformatf("one n=%0d result", n), {b_idx, b_rdata}, {e_idx, 12'h100 + {9'd0, e_idx}});
      if (b_done) cnt = n;
      tick();
    end
    check("one done_at", cnt, 16);

`ifdef ASSAY_PAUSE_EN
    // Five paused cycles inside the layer-1 dispense
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int opened = 0;
      int done_at = -1;
      for (int n = 0; n < 50; n++) begin
        if (ds_buffer[2:1] == 2'b11) opened++;
        if (done) done_at = n;
        if (n == 5) pause = 1'b1;
        if (n == 10) pause = 1'b0;
        tick();
      end
      check("pause_l1_open_cycles", opened, 2);
      check("pause_done_at", done_at, 41);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dilution_tree_sequencer.md
Name: dilution_tree_sequencer

Overview:
- Timed controller for the 4-layer protein dilution/mix fabric (sample/buffer dispense into dilutor layers, reagent dispense into the final mixers).
- Sits directly upstream of the fabric. Drives its dispense valves layer by layer and holds valves closed during each mix interval.
- After the last layer, scans the 8 optical outputs through a shared detector and returns one captured result per channel.

Parameters:
- DISPENSE_CYCLES, 64, cycles each layer's valves stay open (>=1)
- MIX_CYCLES, 1024, cycles of closed-valve mixing per layer (>=1)
- READ_CYCLES, 16, cycles per detector channel (>=1)
- TIMER_W, 16, phase timer width; each *_CYCLES value must be <= 2^TIMER_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin assay; sampled only in IDLE
- abort  in  1  terminate assay
- ds_sample  out  1  sample dispense valve
- ds_buffer  out  7  buffer valves; bit i = buffer inlet i+1
- ds_reagent  out  8  reagent valves; bit i = reagent inlet i+1
- mix_active  out  4  one-hot layer currently mixing
- detect_sel  out  3  optical channel under test
- detect_strobe  out  1  detector trigger
- detect_data  in  12  detector reading
- result_valid  out  1  one-cycle result pulse
- result_idx  out  3  channel of result_data
- result_data  out  12  captured reading
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort acknowledge

Behaviour:
- Reset (async, any time including mid-assay): state IDLE, timer 0, layer 0, channel 0, all outputs 0.
- All outputs are registered.
- States: IDLE, DISP, MIX, READ, DONE. Layer counter L runs 0..3; channel counter C runs 0..7.
- IDLE: start=1 and abort=0 -> DISP, L=0, timer loaded to DISPENSE_CYCLES-1.
- Valve pattern is active only in DISP:
  - L0: ds_sample and ds_buffer[0]
  - L1: ds_buffer[2:1]
  - L2: ds_buffer[6:3]
  - L3: ds_reagent[7:0]
- Valve pattern is asserted from the cycle after start is accepted, for exactly DISPENSE_CYCLES cycles.
- Timer decrements each cycle. A phase ends in the cycle where timer == 0.
- DISP end -> MIX: valves 0, mix_active = 1<<L, timer loaded to MIX_CYCLES-1.
- MIX end:
  - L<3: L+1 and go to DISP.
  - L==3: go to READ with C=0, mix_active=0.
- READ: detect_sel=C for the whole channel window of READ_CYCLES cycles. detect_strobe=1 in the first cycle of the window only.
- Last cycle of a channel window:
  - detect_data is registered into result_data, and result_idx=C.
  - result_valid=1 in the following cycle.
  - C<7: C+1 and stay in READ. C==7: go to DONE.
- DONE: done=1 for one cycle, coincident with result_valid for channel 7. Then IDLE.
- Busy duration per assay: 4*(DISPENSE_CYCLES+MIX_CYCLES) + 8*READ_CYCLES + 1 cycles. With defaults this is 4481.
- start is ignored while busy. abort is ignored in IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all valves/mix/detect outputs 0.
  - aborted=1 for one cycle. No done and no further result_valid.
- start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- Timer never wraps. It is always reloaded before it decrements past 0.

Optional Feature:
- Macro ASSAY_PAUSE_EN.
- When defined:
  - Extra input port pause (1 bit).
  - While pause=1 in DISP/MIX/READ: timer and counters hold, all valve outputs and detect_strobe are forced 0, mix_active holds.
  - A dispense phase therefore totals exactly DISPENSE_CYCLES open-valve cycles across pauses. A strobe suppressed in the first window cycle is issued on the first unpaused cycle instead.
  - abort overrides pause. pause is ignored in IDLE/DONE.
- When undefined: no pause port; behaviour is identical to pause tied 0.

Test Plan:
- Reset: assert rst mid-cycle with defaults -> every output 0 immediately; busy=0 after release.
- Full run with DISPENSE_CYCLES=2, MIX_CYCLES=3, READ_CYCLES=2; detect_data = 0x100+detect_sel -> the run must show:
  - valve groups open 2 cycles each in order L0..L3, mix_active 0001/0010/0100/1000 for 3 cycles each;
  - 8 strobes and result_valid with idx 0..7, data 0x100..0x107;
  - done exactly 37 cycles after busy rises.
- Abort in L2 MIX, same params -> IDLE next cycle, aborted one cycle, valves 0, no done or result_valid afterward; a new start then runs the full sequence.
- Start pulses while busy are ignored, and timing is unchanged versus the full run. start+abort together in IDLE -> busy stays 0.
- Boundary: all *_CYCLES=1 -> each valve group open 1 cycle, strobe every cycle in READ, done 17 cycles after busy rises.
- ASSAY_PAUSE_EN: pause for 5 cycles in the middle of the L1 DISP -> ds_buffer[2:1] shows 2 open cycles total, and done is delayed by exactly 5 cycles.
